// File: rtl/rc4_encrypt.sv
// ============================================================================
// Module   : rc4_encrypt
// Purpose  : RC4 stream encryptor (N-bit words, one-word key) with
//            valid/ready on input and output. Optional macro RC4_DROP_EN
//            discards the first 2^N keystream words before streaming.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rc4_encrypt #(
   parameter int N = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] password,
   input  logic         start,
   input  logic [N-1:0] data_in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] data_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         init_done,
   output logic         busy
);

   localparam int DEPTH = 1 << N;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_KSA    = 3'd2,
      ST_STREAM = 3'd3,
      ST_SWAP   = 3'd4,
      ST_XOR    = 3'd5,
      ST_OUT    = 3'd6
`ifdef RC4_DROP_EN
      , ST_DROP = 3'd7
`endif
   } state_t;

   state_t       r_state;
   logic [N-1:0] r_s [0:DEPTH-1];
   logic [N-1:0] r_i;
   logic [N-1:0] r_j;
   logic [N-1:0] r_k;
   logic [N-1:0] r_key;
   logic [N-1:0] r_hold;
   logic [N-1:0] r_data_out;
   logic         r_out_valid;
   logic         r_in_ready;
   logic         r_init_done;
   logic         r_busy;
`ifdef RC4_DROP_EN
   logic         r_ph;
`endif

   logic [N-1:0] w_si;
   logic [N-1:0] w_j_ksa;
   logic [N-1:0] w_j_prga;
   logic [N-1:0] w_t;
   logic [N-1:0] w_ks;
   logic         w_init_en;
   logic         w_sw_en;
   logic [N-1:0] w_sw_b;

   assign w_si     = r_s[r_i];
   assign w_j_ksa  = r_j + w_si + r_key;
   assign w_j_prga = r_j + w_si;
   // Keystream index uses the already-swapped table (registered after SWAP)
   assign w_t      = r_s[r_i] + r_s[r_j];
   assign w_ks     = r_s[w_t];

   always_comb begin
      w_init_en = (r_state == ST_INIT);
      w_sw_en   = 1'b0;
      w_sw_b    = w_j_prga;
      case (r_state)
         ST_KSA: begin
            w_sw_en = 1'b1;
            w_sw_b  = w_j_ksa;
         end
         ST_SWAP: w_sw_en = 1'b1;
`ifdef RC4_DROP_EN
         ST_DROP: w_sw_en = r_ph;
`endif
         default: w_sw_en = 1'b0;
      endcase
   end

   // The table is deliberately not reset; INIT rewrites every entry.
   always_ff @(posedge clk) begin
      if (w_init_en) begin
         r_s[r_k] <= r_k;
      end else if (w_sw_en) begin
         r_s[r_i]    <= r_s[w_sw_b];
         r_s[w_sw_b] <= r_s[r_i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_i         <= '0;
         r_j         <= '0;
         r_k         <= '0;
         r_key       <= '0;
         r_hold      <= '0;
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_init_done <= 1'b0;
         r_busy      <= 1'b0;
`ifdef RC4_DROP_EN
         r_ph        <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_key   <= password;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_INIT;
               end
            end
            ST_INIT: begin
               r_k <= r_k + 1'b1;
               if (r_k == '1) begin
                  r_i     <= '0;
                  r_j     <= '0;
                  r_state <= ST_KSA;
               end
            end
            ST_KSA: begin
               r_j <= w_j_ksa;
               r_i <= r_i + 1'b1;
               if (r_i == '1) begin
                  r_i <= '0;
                  r_j <= '0;
`ifdef RC4_DROP_EN
                  r_k     <= '0;
                  r_ph    <= 1'b0;
                  r_state <= ST_DROP;
`else
                  r_init_done <= 1'b1;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_STREAM;
`endif
               end
            end
`ifdef RC4_DROP_EN
            ST_DROP: begin
               if (!r_ph) begin
                  r_i  <= r_i + 1'b1;
                  r_ph <= 1'b1;
               end else begin
                  r_j  <= w_j_prga;
                  r_ph <= 1'b0;
                  r_k  <= r_k + 1'b1;
                  if (r_k == '1) begin
                     r_init_done <= 1'b1;
                     r_in_ready  <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= ST_STREAM;
                  end
               end
            end
`endif
            ST_STREAM: begin
               if (start) begin
                  r_key       <= password;
                  r_k         <= '0;
                  r_init_done <= 1'b0;
                  r_in_ready  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_INIT;
               end else if (in_valid) begin
                  r_hold     <= data_in;
                  r_i        <= r_i + 1'b1;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_SWAP;
               end
            end
            ST_SWAP: begin
               r_j     <= w_j_prga;
               r_state <= ST_XOR;
            end
            ST_XOR: begin
               r_data_out  <= r_hold ^ w_ks;
               r_out_valid <= 1'b1;
               r_state     <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_STREAM;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign data_out  = r_data_out;
   assign out_valid = r_out_valid;
   assign init_done = r_init_done;
   assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rc4_encrypt.sv
// ============================================================================
// Module   : tb_rc4_encrypt
// Purpose  : Directed self-checking bench for rc4_encrypt (encrypt + loopback).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rc4_encrypt;

   localparam int N = 7;
`ifdef RC4_DROP_EN
   localparam int KS_CYC = 512;
`else
   localparam int KS_CYC = 256;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] password, data_in, data_out;
   logic         start, in_valid, in_ready, out_valid, out_ready, init_done, busy;
   logic [N-1:0] rx_password, rx_data_in, rx_data_out;
   logic         rx_start, rx_in_valid, rx_in_ready, rx_out_valid, rx_init_done, rx_busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [N-1:0] m_s [128];
   logic [N-1:0] m_i, m_j;
   logic [N-1:0] ct [5];
   logic [N-1:0] pt [5];
   logic [N-1:0] ks, got, exp_bp;

   always #5 clk = ~clk;

   rc4_encrypt #(.N(N)) u_dut (
      .clk(clk), .rst(rst), .password(password), .start(start),
      .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
      .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
      .init_done(init_done), .busy(busy)
   );

   rc4_encrypt #(.N(N)) u_rx (
      .clk(clk), .rst(rst), .password(rx_password), .start(rx_start),
      .data_in(rx_data_in), .in_valid(rx_in_valid), .in_ready(rx_in_ready),
      .data_out(rx_data_out), .out_valid(rx_out_valid), .out_ready(1'b1),
      .init_done(rx_init_done), .busy(rx_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_swap(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] t;
      t      = m_s[a];
      m_s[a] = m_s[b];
      m_s[b] = t;
   endtask

   // Plain software RC4 over 7-bit words with a single-word key
   task automatic model_key(input logic [N-1:0] key);
      for (int k = 0; k < 128; k++) m_s[k] = 7'(k);
      m_j = '0;
      for (int k = 0; k < 128; k++) begin
         m_j = 7'(m_j + m_s[k] + key);
         m_swap(7'(k), m_j);
      end
      m_i = '0;
      m_j = '0;
`ifdef RC4_DROP_EN
      for (int k = 0; k < 128; k++) begin
         m_i = 7'(m_i + 1);
         m_j = 7'(m_j + m_s[m_i]);
         m_swap(m_i, m_j);
      end
`endif
   endtask

   task automatic model_ks(output logic [N-1:0] o);
      m_i = 7'(m_i + 1);
      m_j = 7'(m_j + m_s[m_i]);
      m_swap(m_i, m_j);
      o = m_s[7'(m_s[m_i] + m_s[m_j])];
   endtask

   task automatic send_char(input string tag, input logic [N-1:0] c,
                            input logic [N-1:0] exp, output logic [N-1:0] obs);
      int w = 0;
      while (!in_ready && w < 20) begin tick(); w++; end
      check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
      data_in  = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
      tick();
      check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(data_out), 32'(exp));
      obs = data_out;
   endtask

   task automatic rx_send(input string tag, input logic [N-1:0] c, input logic [N-1:0] exp);
      int w = 0;
      while (!rx_in_ready && w < 20) begin tick(); w++; end
      check({tag, "_ready_wait"}, 32'(rx_in_ready), 32'd1);
      rx_data_in  = c;
      rx_in_valid = 1'b1;
      tick();
      rx_in_valid = 1'b0;
      tick();
      tick();
      check({tag, "_valid"}, 32'(rx_out_valid), 32'd1);
      check({tag, "_data"}, 32'(rx_data_out), 32'(exp));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; password = '0; data_in = '0; in_valid = 1'b0; out_ready = 1'b1;
      rx_start = 1'b0; rx_password = '0; rx_data_in = '0; rx_in_valid = 1'b0;
      pt[0] = 7'h48; pt[1] = 7'h45; pt[2] = 7'h4C; pt[3] = 7'h4C; pt[4] = 7'h4F;

      // Reset / idle
      repeat (3) tick();
      rst = 1'b1;
      for (int c = 0; c < 50; c++) begin
         tick();
         check("idle_outs", {21'd0, data_out, out_valid, in_ready, init_done, busy}, 32'd0);
      end

      // Key schedule timing on both instances
      password = 7'h2A; rx_password = 7'h2A;
      start = 1'b1; rx_start = 1'b1;
      tick();
      start = 1'b0; rx_start = 1'b0;
      check("ks_busy", 32'(busy), 32'd1);
      check("ks_done_early0", 32'(init_done), 32'd0);
      repeat (KS_CYC - 1) tick();
      check("ks_done_early", 32'(init_done), 32'd0);
      check("ks_busy_late", 32'(busy), 32'd1);
      tick();
      check("ks_done", 32'(init_done), 32'd1);
      check("ks_in_ready", 32'(in_ready), 32'd1);
      check("ks_busy_clr", 32'(busy), 32'd0);
      check("rx_ks_done", 32'(rx_init_done), 32'd1);

      // Stream "HELLO"
      model_key(7'h2A);
      for (int c = 0; c < 5; c++) begin
         model_ks(ks);
         send_char("hello", pt[c], pt[c] ^ ks, got);
         ct[c] = got;
      end

      // Loopback through the second instance
      rx_send("loop0", ct[0], 7'h48);
      rx_send("loop1", ct[1], 7'h45);
      rx_send("loop2", ct[2], 7'h4C);
      rx_send("loop3", ct[3], 7'h4C);
      rx_send("loop4", ct[4], 7'h4F);

      // Backpressure
      out_ready = 1'b0;
      model_ks(ks);
      exp_bp = 7'h58 ^ ks;
      send_char("bp_x", 7'h58, exp_bp, got);
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_hold_data", 32'(data_out), 32'(exp_bp));
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_release", 32'(out_valid), 32'd0);
      model_ks(ks);
      send_char("bp_y", 7'h59, 7'h59 ^ ks, got);

      // Rekey mid-stream; start must win over a simultaneous in_valid
      tick();
      password = 7'h11; start = 1'b1; data_in = 7'h7F; in_valid = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b0;
      check("rekey_done_drop", 32'(init_done), 32'd0);
      check("rekey_busy", 32'(busy), 32'd1);
      check("rekey_in_ready", 32'(in_ready), 32'd0);
      repeat (KS_CYC - 1) tick();
      check("rekey_done_early", 32'(init_done), 32'd0);
      tick();
      check("rekey_done", 32'(init_done), 32'd1);
      model_key(7'h11);
      model_ks(ks);
      send_char("rekey_a", 7'h41, 7'h41 ^ ks, got);

      // Reset while in SWAP
      tick();
      data_in  = 7'h42;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      check("rst_swap_outs", {21'd0, data_out, out_valid, in_ready, init_done, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
      check("rst_stay_idle", {21'd0, data_out, out_valid, in_ready, init_done, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rc4_encrypt.md
Name: rc4_encrypt

Overview:
- Transmit-side counterpart of the text-path decryptor.
- Expands a 7-bit password into a 2^N-entry RC4 state table (S-box).
- Generates one keystream word per accepted plaintext character and XORs it onto the character.
- Output ciphertext is bit-compatible with a receiver keyed with the same password and fed the characters in the same order. Sits between the text source and the channel, with valid/ready on both sides.

Parameters:
- N, 7, character/bus width; S-box has 2^N entries of N bits; all index arithmetic is mod 2^N.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- password  in  N  key word; sampled only when start is accepted
- start  in  1  request (re)key; honoured in IDLE and STREAM only
- data_in  in  N  plaintext character
- in_valid  in  1  data_in valid
- in_ready  out  1  block can accept data_in this cycle
- data_out  out  N  ciphertext character
- out_valid  out  1  data_out valid
- out_ready  in  1  downstream accepts data_out
- init_done  out  1  key schedule complete, keystream available
- busy  out  1  high in INIT/KSA (and DROP when enabled)

Behaviour:
- Reset (rst=0, async): state=IDLE; i=j=0; key register=0; data_out=0; out_valid=0; in_ready=0; init_done=0; busy=0. The S-box is not cleared; INIT rewrites it.
- The S-box is a register array with combinational read. At most one swap occurs per cycle.
- IDLE: on start=1, latch password and go to INIT with k=0.
- INIT: S[k]=k, one entry per cycle, 2^N cycles. After the last write, go to KSA with i=0, j=0.
- KSA: one step per cycle, 2^N cycles. Each step: j=j+S[i]+key, then swap S[i],S[j], then i++. After the last step, set i=j=0, set init_done=1, go to STREAM.
- Timing: if start is accepted at edge e, init_done is visible after edge e+2·2^N (e+256 for N=7).
- STREAM: in_ready=1.
  - On in_valid&&in_ready, latch data_in into d_hold, set i=i+1, go to SWAP.
  - If start=1 in STREAM, start wins over in_valid: re-latch password, clear init_done, go to INIT.
- SWAP: j=j+S[i]; swap S[i],S[j]; go to XOR.
- XOR: data_out <= d_hold ^ S[S[i]+S[j]] (post-swap values); out_valid <= 1; go to OUT.
- OUT: hold data_out/out_valid stable until out_ready=1. On that edge, clear out_valid and return to STREAM.
- Latency and throughput: out_valid rises 2 edges after the accepting edge. Best-case throughput is one character per 4 cycles.
- in_ready=0 in every state except STREAM; a data_in presented then is neither consumed nor dropped.
- start in INIT/KSA/SWAP/XOR/OUT is ignored.
- Mid-operation reset returns to IDLE immediately. Any pending output is lost and init_done drops; a new start is required.
- i and j wrap mod 2^N with no special handling.
- Sum j+S[i]+key is computed at N bits (carries discarded).

Optional Feature:
- Macro RC4_DROP_EN.
- Defined: after KSA, enter DROP and run 2^N PRGA steps (2 cycles each: increment/swap, discard) before setting init_done. Time from start to init_done becomes 4·2^N cycles. The receiver must be built with the same option.
- Undefined: KSA goes directly to STREAM; the DROP state and its logic are absent.

Test Plan:
- Reset/idle: rst=0 then 1, no start → data_out=0, out_valid=0, in_ready=0, init_done=0, busy=0 for 50 cycles.
- Key schedule timing: password=7'h2A, start pulse at edge e → busy=1 from e+1; init_done=1 and in_ready=1 exactly after edge e+256 (e+512 with RC4_DROP_EN); S-box matches a software RC4 model (N=7, one-word key).
- Stream: password=7'h2A, send "HELLO" (48,45,4C,4C,4F) with out_ready=1 → five outputs equal plaintext XOR model keystream, each 2 edges after acceptance.
- Loopback: ciphertext from the stream test fed into a second instance keyed 7'h2A → outputs 48,45,4C,4C,4F.
- Backpressure: out_ready=0 for 10 cycles after out_valid → data_out stable, in_ready=0, no i/j change; release → the next character's keystream is unchanged versus the no-stall run.
- Rekey/reset mid-stream: start with password=7'h11 while in STREAM → init_done drops; after 256 cycles "A" (41) encrypts per the 7'h11 model. Separately, rst=0 during SWAP → all outputs return to reset values at once.
